// File: rtl/serial_wide_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_wide_add_ctrl
//
// Purpose:
//   Adds two W-bit operands (W = 8*NBYTES) one byte per enabled clock cycle,
//   least significant byte first. A carry register links consecutive byte
//   slices. The operation runs through three states:
//     IDLE -> waits for start, then captures the operands and carry-in
//     RUN  -> performs one byte slice per cycle while en is high
//     DONE -> single-cycle completion pulse, then back to IDLE
//   The result and carry-out stay valid from DONE until the next accepted
//   start.
//
// Parameters:
//   NBYTES  operand width in bytes (1..8), W = 8*NBYTES
//
// Ports:
//   clk     input   1   single clock, all state changes on its rising edge
//   rst     input   1   synchronous active-high reset
//   start   input   1   request a new operation (only honoured in IDLE)
//   en      input   1   slice enable, 0 stalls the byte sequence in RUN
//   a       input   W   operand A, captured on the accepting edge
//   b       input   W   operand B, captured on the accepting edge
//   cin     input   1   carry into byte 0, captured on the accepting edge
//   sub     input   1   (only with SERIAL_ADD_SUB_EN) 1 selects A - B
//   busy    output  1   high while in RUN
//   done    output  1   high for the single DONE cycle
//   sum     output  W   A + B + cin modulo 2^W (or A - B when subtracting)
//   cout    output  1   carry out of the top byte (1 = no borrow on subtract)
//
// Configuration:
//   SERIAL_ADD_SUB_EN  when defined, adds the sub port and subtract mode.
//                      When undefined the block is add-only and has no sub.
// ---------------------------------------------------------------------------
module serial_wide_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  en,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
);

    localparam int W    = 8 * NBYTES;
    // A one-byte configuration still needs a one-bit counter to stay legal.
    localparam int CNTW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNTW-1:0] LAST_BYTE = CNTW'(NBYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic            creg_q,  creg_d;
    logic [W-1:0]    opA_q,   opA_d;
    logic [W-1:0]    opB_q,   opB_d;
    logic [W-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;

    logic            subSel;
    logic [7:0]      aByte;
    logic [7:0]      bByte;
    logic [7:0]      sliceSum;
    logic            sliceCarry;

`ifdef SERIAL_ADD_SUB_EN
    assign subSel = sub;
`else
    assign subSel = 1'b0;
`endif

    // Pick the operand bytes addressed by the byte counter. A compare per
    // byte lane keeps the mux free of variable part-selects.
    always_comb begin
        aByte = 8'h00;
        bByte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CNTW'(i)) begin
                aByte = opA_q[8*i +: 8];
                bByte = opB_q[8*i +: 8];
            end
        end
    end

    // The single 8-bit adder slice shared by every byte position.
    always_comb begin
        {sliceCarry, sliceSum} = {1'b0, aByte} + {1'b0, bByte} + {8'h00, creg_q};
    end

    // Next-state logic. Subtraction is folded into the capture step: the
    // stored B is inverted and the carry register preloaded with 1, so the
    // RUN datapath is identical for both modes and cin is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        creg_d  = creg_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d   = a;
                    opB_d   = subSel ? ~b : b;
                    creg_d  = subSel ? 1'b1 : cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (en) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (cnt_q == CNTW'(i)) begin
                            sum_d[8*i +: 8] = sliceSum;
                        end
                    end
                    creg_d = sliceCarry;
                    if (cnt_q == LAST_BYTE) begin
                        cout_d  = sliceCarry;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset clears the control and result state but leaves
    // the captured operands alone; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            creg_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            creg_q  <= creg_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_ff @(posedge clk) begin
        opA_q <= opA_d;
        opB_q <= opB_d;
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_wide_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_wide_add_ctrl
//
// Directed bench for serial_wide_add_ctrl with NBYTES = 4. Each operation
// is started, driven with a chosen enable pattern and then compared with
// hand-computed sums, carries, latencies and busy-cycle counts.
// ---------------------------------------------------------------------------
module tb_serial_wide_add_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
`ifdef SERIAL_ADD_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;

    int assertCount = 0;
    int failCount   = 0;

    serial_wide_add_ctrl #(.NBYTES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .en   (en),
        .a    (a),
        .b    (b),
        .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub  (sub),
`endif
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 ns past it, so both sampling and
    // driving happen well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present a start request for one edge, then scramble the operand inputs
    // so any late sampling by the design corrupts the result.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input logic opCin);
        a     = opA;
        b     = opB;
        cin   = opCin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~opA ^ 32'h5A5A_5A5A;
        b     = ~opB ^ 32'hA5A5_A5A5;
        cin   = ~opCin;
    endtask

    // Full operation: accept, run with an optional stall of stallLen cycles
    // once stallAt bytes are done, optionally keep start asserted during RUN,
    // then check the DONE cycle and the cycle after it. With pulseInDone the
    // DONE cycle carries a start request that must be ignored; start is then
    // left high so the caller can see it accepted in the following IDLE.
    task automatic runOp(input string tag, input logic [31:0] opA,
                         input logic [31:0] opB, input logic opCin,
                         input int stallAt, input int stallLen, input bit holdStart,
                         input bit pulseInDone, input logic [31:0] expSum,
                         input logic expCout, input int expLat);
        int lat;
        int busyCycles;
        int enabledBytes;
        int stallLeft;
        lat          = 0;
        busyCycles   = 0;
        enabledBytes = 0;
        stallLeft    = stallLen;
        en           = 1'b1;
        applyStimulus(opA, opB, opCin);
        checkOutput({tag, " busy after accept"}, 64'(busy), 64'(1'b1));
        checkOutput({tag, " sum cleared"}, 64'(sum), 64'h0);
        while (!done && lat < 40) begin
            if (busy) busyCycles++;
            if (holdStart) begin
                start = 1'b1;
                a     = 32'h7777_7777;
                b     = 32'h1234_4321;
                cin   = 1'b1;
            end
            if (enabledBytes == stallAt && stallLeft > 0) begin
                en = 1'b0;
                stallLeft--;
            end else begin
                en = 1'b1;
                if (busy) enabledBytes++;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        en    = 1'b1;
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'(expLat));
        checkOutput({tag, " busy in DONE"}, 64'(busy), 64'(1'b0));
        checkOutput({tag, " sum"}, 64'(sum), 64'(expSum));
        checkOutput({tag, " cout"}, 64'(cout), 64'(expCout));
        if (pulseInDone) begin
            start = 1'b1;
            a     = 32'h0000_0001;
            b     = 32'h0000_0001;
            cin   = 1'b0;
        end
        tick();
        checkOutput({tag, " done one cycle"}, 64'(done), 64'(1'b0));
        checkOutput({tag, " idle after DONE"}, 64'(busy), 64'(1'b0));
        checkOutput({tag, " sum held"}, 64'(sum), 64'(expSum));
        checkOutput({tag, " cout held"}, 64'(cout), 64'(expCout));
    endtask

    initial begin
        int doneSeen;
        int busySeen;
        rst   = 1'b1;
        start = 1'b0;
        en    = 1'b1;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        tick();
        tick();
        checkOutput("reset busy", 64'(busy), 64'(1'b0));
        checkOutput("reset done", 64'(done), 64'(1'b0));
        checkOutput("reset sum", 64'(sum), 64'h0);
        checkOutput("reset cout", 64'(cout), 64'(1'b0));

        // Reset outranks a simultaneous start request.
        start = 1'b1;
        a     = 32'h0000_00FF;
        b     = 32'h0000_0001;
        tick();
        checkOutput("rst over start", 64'(busy), 64'(1'b0));
        rst = 1'b0;

        // Byte carry; this is also the first edge after reset release.
        runOp("byte carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 0, 1'b0, 1'b0,
              32'h0000_0100, 1'b0, 4);

        // Carry ripples through every byte.
        runOp("full wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 0, 1'b0, 1'b0,
              32'h0000_0000, 1'b1, 4);

        // Two stalled cycles after byte 1 delay done by two.
        runOp("stall", 32'h1234_5678, 32'h1111_1111, 1'b0, 2, 2, 1'b0, 1'b0,
              32'h2345_6789, 1'b0, 6);

        // Carry across three bytes.
        runOp("three byte carry", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 0, 0, 1'b0, 1'b0,
              32'h0100_0000, 1'b0, 4);

        // start held high through RUN with other operands is ignored.
        runOp("start in RUN", 32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 1'b1, 1'b0,
              32'h0000_0001, 1'b1, 4);

        // start in DONE is ignored, the next IDLE start (1 + 1) is accepted.
        runOp("start in DONE", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 0, 0, 1'b0, 1'b1,
              32'hFFFF_FFFF, 1'b0, 4);
        tick();
        start = 1'b0;
        checkOutput("idle start accepted", 64'(busy), 64'(1'b1));
        for (int i = 0; i < 4; i++) tick();
        checkOutput("idle start done", 64'(done), 64'(1'b1));
        checkOutput("idle start sum", 64'(sum), 64'h0000_0002);
        tick();

        // Reset after two bytes aborts the operation for good.
        applyStimulus(32'h0101_0101, 32'h0101_0101, 1'b0);
        tick();
        tick();
        checkOutput("partial sum", 64'(sum), 64'h0000_0202);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort sum", 64'(sum), 64'h0);
        checkOutput("abort cout", 64'(cout), 64'(1'b0));
        checkOutput("abort busy", 64'(busy), 64'(1'b0));
        doneSeen = 0;
        busySeen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) doneSeen++;
            if (busy) busySeen++;
            tick();
        end
        checkOutput("abort no done", 64'(doneSeen), 64'h0);
        checkOutput("abort no resume", 64'(busySeen), 64'h0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        runOp("sub 5-7", 32'h0000_0005, 32'h0000_0007, 1'b0, 0, 0, 1'b0, 1'b0,
              32'hFFFF_FFFE, 1'b0, 4);
        runOp("sub 7-5", 32'h0000_0007, 32'h0000_0005, 1'b1, 0, 0, 1'b0, 1'b0,
              32'h0000_0002, 1'b1, 4);
        sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
